return_address_stack: RTL and testbench

Hardware return-address stack for the single-cycle MIPS datapath. It answers the control unit's stack commands: JAL pushes the link address, and JS (funct 001000 under opcode 000000) pops it to form the jump target. The block sits beside the register file and PC logic. It replaces the data-memory stack path for return addresses and reports overflow and underflow to the debug/status logic.

---
 rtl/return_address_stack_if.sv | 29 ++
 rtl/return_address_stack.sv | 86 ++++++++
 tb/tb_return_address_stack.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/return_address_stack_if.sv
// Command/status bundle between the control unit and the return-address stack.
interface return_address_stack_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic [AW-1:0] push_data;
  logic          halt;
  logic          clear;
  logic [AW-1:0] top_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, push_data, halt, clear,
    input  top_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, halt, clear,
    output top_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/return_address_stack.sv
// Circular return-address stack: JAL pushes PC+4, JS pops it; wraps on overflow,
// sticky overflow/underflow flags for status logic.
module return_address_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 32
) (
  input  logic                    Clock,
  input  logic                    Reset,
  return_address_stack_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp, sp_nxt, sp_m1, waddr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ovf, ovf_nxt, unf, unf_nxt, we;
  logic          is_empty, is_full;

  assign sp_m1    = sp - 1'b1;
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  always_comb begin
    sp_nxt  = sp;
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    unf_nxt = unf;
    we      = 1'b0;
    waddr   = sp;
    if (!bus.halt) begin
      if (bus.clear) begin
        sp_nxt  = '0;
        cnt_nxt = '0;
      end else if (bus.push && bus.pop) begin
        we = 1'b1;
        if (!is_empty) begin
          waddr = sp_m1;
        end else begin
          // popping nothing: flag it, then the push lands as the only entry
          unf_nxt = 1'b1;
          sp_nxt  = sp + 1'b1;
          cnt_nxt = CW'(1);
        end
      end else if (bus.push) begin
        we     = 1'b1;
        sp_nxt = sp + 1'b1;
        if (is_full) ovf_nxt = 1'b1;  // oldest entry silently overwritten
        else         cnt_nxt = cnt + 1'b1;
      end else if (bus.pop) begin
        if (!is_empty) begin
          sp_nxt  = sp_m1;
          cnt_nxt = cnt - 1'b1;
        end else begin
          unf_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

  // storage is deliberately left unreset; count gates visibility
  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= bus.push_data;
  end

  assign bus.top_data  = is_empty ? '0 : mem[sp_m1];
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack: queue-based reference stack plus
// an expected-pop queue compared in the pop cycle.
module tb_return_address_stack;
  localparam int DEPTH = 16;
  localparam int AW    = 32;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  return_address_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();
  return_address_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  logic [AW-1:0] mdl[$];
  logic [AW-1:0] exp_q[$];
  bit m_ovf = 1'b0, m_unf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] mdl_top();
    return (mdl.size() > 0) ? mdl[$] : '0;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(bus.count), 64'(mdl.size()));
    chk({tag, "_top"},   64'(bus.top_data), 64'(mdl_top()));
    chk({tag, "_empty"}, 64'(bus.empty), 64'(mdl.size() == 0));
    chk({tag, "_full"},  64'(bus.full), 64'(mdl.size() == DEPTH));
    chk({tag, "_ovf"},   64'(bus.overflow), 64'(m_ovf));
    chk({tag, "_unf"},   64'(bus.underflow), 64'(m_unf));
  endtask

  task automatic model_step(input bit pu, po, cl, h, input logic [AW-1:0] d);
    if (h) return;
    if (cl) mdl.delete();
    else if (pu && po) begin
      if (mdl.size() > 0) mdl[mdl.size()-1] = d;
      else begin m_unf = 1'b1; mdl.push_back(d); end
    end else if (pu) begin
      if (mdl.size() == DEPTH) begin void'(mdl.pop_front()); m_ovf = 1'b1; end
      mdl.push_back(d);
    end else if (po) begin
      if (mdl.size() > 0) void'(mdl.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  // Drive one command for one cycle; entered and left 1 time unit after an edge.
  task automatic cmd(input string tag, input bit pu, po, cl, h, input logic [AW-1:0] d);
    logic [AW-1:0] e;
    bus.push = pu; bus.pop = po; bus.clear = cl; bus.halt = h; bus.push_data = d;
    if (po && !h && !cl) exp_q.push_back(mdl_top());
    #1;
    if (po && !h && !cl) begin
      e = exp_q.pop_front();
      chk({tag, "_popval"}, 64'(bus.top_data), 64'(e));
    end
    @(posedge Clock);
    model_step(pu, po, cl, h, d);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.halt = 1'b0;
    check_state(tag);
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.halt = 1'b0; bus.push_data = '0;
    Reset = 1'b0;
    #12;
    chk("rst_empty", 64'(bus.empty), 64'd1);
    check_state("rst");
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;

    // LIFO order
    cmd("p1", 1, 0, 0, 0, 32'h0040_0004);
    cmd("p2", 1, 0, 0, 0, 32'h0040_0010);
    cmd("p3", 1, 0, 0, 0, 32'h0040_001C);
    chk("lifo_cnt", 64'(bus.count), 64'd3);
    chk("lifo_top", 64'(bus.top_data), 64'h0040_001C);
    repeat (3) cmd("lifo_pop", 0, 1, 0, 0, '0);
    chk("lifo_unf", 64'(bus.underflow), 64'd0);

    // underflow then push
    cmd("uf_pop", 0, 1, 0, 0, '0);
    chk("uf_flag", 64'(bus.underflow), 64'd1);
    cmd("uf_push", 1, 0, 0, 0, 32'h100);
    chk("uf_top", 64'(bus.top_data), 64'h100);

    // overflow wrap
    cmd("ov_clr", 0, 0, 1, 0, '0);
    for (int i = 0; i <= 16; i++) cmd("ov_push", 1, 0, 0, 0, AW'(32'h1000 + 4 * i));
    chk("ov_flag", 64'(bus.overflow), 64'd1);
    chk("ov_top", 64'(bus.top_data), 64'h1040);
    repeat (16) cmd("ov_pop", 0, 1, 0, 0, '0);
    chk("ov_lost", 64'(bus.empty), 64'd1);

    // replace top
    cmd("rp_clr", 0, 0, 1, 0, '0);
    cmd("rp_a", 1, 0, 0, 0, 32'hA0);
    cmd("rp_b", 1, 0, 0, 0, 32'hB0);
    cmd("rp_pp", 1, 1, 0, 0, 32'hC0);
    chk("rp_top", 64'(bus.top_data), 64'hC0);
    cmd("rp_pop", 0, 1, 0, 0, '0);
    chk("rp_expose", 64'(bus.top_data), 64'hA0);

    // halt blocks everything
    cmd("h_clr", 0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) cmd("h_fill", 1, 0, 0, 0, AW'(32'h200 + i));
    cmd("h_push", 1, 0, 0, 1, 32'hDEAD);
    cmd("h_pop", 0, 1, 0, 1, '0);
    cmd("h_clear", 0, 0, 1, 1, '0);
    chk("h_cnt", 64'(bus.count), 64'd3);
    cmd("h_flush", 0, 0, 1, 0, '0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cmd("rnd", r < 45, (r >= 35 && r < 85), r >= 97, (r >= 92 && r < 97), $urandom);
    end

    // async reset mid-cycle with count=5, overflow=1
    cmd("ar_clr", 0, 0, 1, 0, '0);
    for (int i = 0; i < 17; i++) cmd("ar_push", 1, 0, 0, 0, AW'(32'h3000 + i));
    repeat (11) cmd("ar_pop", 0, 1, 0, 0, '0);
    chk("ar_pre_cnt", 64'(bus.count), 64'd5);
    #2;
    Reset = 1'b0;
    #1;
    mdl.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state("ar");
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    cmd("ar_after", 1, 0, 0, 0, 32'h4444);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
